// File: rtl/sha256_stream_ctrl.sv
// sha256_stream_ctrl: streaming front-end for a SHA-256 compression core.
// Packs big-endian message words into 512-bit blocks, applies the FIPS 180-4
// padding (0x80 marker, zero fill, 64-bit bit length), sequences the core
// with init/next pulses and hands the final digest out on a valid/ready port.
module sha256_stream_ctrl #(
    parameter int CNT_W = 61
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         s_last,
    input  logic [1:0]   s_bytes,
    output logic         core_init,
    output logic         core_next,
    output logic [511:0] core_block,
    input  logic         core_ready,
    input  logic [255:0] core_digest,
    input  logic         core_digest_valid,
    output logic [255:0] m_digest,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         busy
);

    typedef enum logic [2:0] {FILL, START, WAIT, EXTRA, OUT} state_t;

    state_t state, state_nx;

    // Ascending packed range puts word 0 in the top 32 bits of core_block.
    logic [0:15][31:0]  blk_buf;
    logic [3:0]         w_idx;
    logic [CNT_W-1:0]   byte_cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic               first;
    logic               last_blk;
    logic               need_extra;
    logic               mark_extra;
    logic [255:0]       digest_q;
    logic               busy_q;

    logic               acc;
    logic [2:0]         inc;
    logic [31:0]        last_word;
    logic               fits;
    logic [63:0]        len_now;
    logic [63:0]        len_cnt;

    // Message length in bits, zero-extended to the 64-bit length field.
    function automatic logic [63:0] bit_len(input logic [CNT_W-1:0] c);
        logic [63:0] l;
        l = '0;
        l[CNT_W+2:0] = {c, 3'b000};
        return l;
    endfunction

    // Accept/pad helpers for the word currently on the input stream.
    always_comb begin
        acc     = (state == FILL) && s_valid;
        inc     = (s_last && (s_bytes != 2'd0)) ? {1'b0, s_bytes} : 3'd4;
        cnt_nx  = byte_cnt + CNT_W'(inc);
        len_now = bit_len(cnt_nx);
        len_cnt = bit_len(byte_cnt);
        // Length field fits in words 14/15 only if the marker lands at or before word 13.
        fits    = ((s_bytes != 2'd0) && (w_idx <= 4'd13)) ||
                  ((s_bytes == 2'd0) && (w_idx <= 4'd12));
        case (s_bytes)
            2'd1:    last_word = {s_data[31:24], 24'h800000};
            2'd2:    last_word = {s_data[31:16], 16'h8000};
            2'd3:    last_word = {s_data[31:8],  8'h80};
            default: last_word = s_data;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= FILL;
        else          state <= state_nx;
    end

    // Next-state and handshake/pulse outputs.
    always_comb begin
        state_nx  = state;
        s_ready   = 1'b0;
        core_init = 1'b0;
        core_next = 1'b0;
        m_valid   = 1'b0;
        case (state)
            FILL: begin
                s_ready = 1'b1;
                if (acc && (s_last || (w_idx == 4'd15))) state_nx = START;
            end
            START: begin
                if (core_ready) begin
                    core_init = first;
                    core_next = !first;
                    state_nx  = WAIT;
                end
            end
            WAIT: begin
                if (core_digest_valid) begin
                    if (last_blk)        state_nx = OUT;
                    else if (need_extra) state_nx = EXTRA;
                    else                 state_nx = FILL;
                end
            end
            EXTRA: state_nx = START;
            OUT: begin
                m_valid = 1'b1;
                if (m_ready) state_nx = FILL;
            end
            default: state_nx = FILL;
        endcase
    end

    // Block buffer, counters and message flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_buf    <= '0;
            w_idx      <= '0;
            byte_cnt   <= '0;
            first      <= 1'b1;
            last_blk   <= 1'b0;
            need_extra <= 1'b0;
            mark_extra <= 1'b0;
            digest_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (acc) begin
                        busy_q   <= 1'b1;
                        byte_cnt <= cnt_nx;
                        w_idx    <= w_idx + 4'd1;
                        if (s_last) begin
                            blk_buf[w_idx] <= last_word;
                            // Full last word: marker starts the following word.
                            if ((s_bytes == 2'd0) && (w_idx != 4'd15))
                                blk_buf[w_idx + 4'd1] <= 32'h80000000;
                            if (fits) begin
                                blk_buf[14] <= len_now[63:32];
                                blk_buf[15] <= len_now[31:0];
                                last_blk    <= 1'b1;
                            end else begin
                                last_blk   <= 1'b0;
                                need_extra <= 1'b1;
                                mark_extra <= (s_bytes == 2'd0) && (w_idx == 4'd15);
                            end
                        end else begin
                            blk_buf[w_idx] <= s_data;
                            last_blk       <= 1'b0;
                        end
                    end
                end
                START: begin
                    if (core_ready) first <= 1'b0;
                end
                WAIT: begin
                    if (core_digest_valid) begin
                        blk_buf <= '0;
                        w_idx   <= '0;
                        if (last_blk) digest_q <= core_digest;
                    end
                end
                EXTRA: begin
                    if (mark_extra) blk_buf[0] <= 32'h80000000;
                    blk_buf[14] <= len_cnt[63:32];
                    blk_buf[15] <= len_cnt[31:0];
                    last_blk    <= 1'b1;
                    need_extra  <= 1'b0;
                    mark_extra  <= 1'b0;
                end
                OUT: begin
                    if (m_ready) begin
                        byte_cnt <= '0;
                        first    <= 1'b1;
                        busy_q   <= 1'b0;
                        last_blk <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_block = blk_buf;
    assign m_digest   = digest_q;
    assign busy       = busy_q;

endmodule

// File: doc/sha256_stream_ctrl.md
# sha256_stream_ctrl

Streaming front-end and sequencer for the SHA-256 core.
- Accepts a message as big-endian 32-bit words over a valid/ready stream and assembles 512-bit blocks.
- Applies FIPS 180-4 padding: the 0x80 marker, zero fill and the 64-bit bit-length field.
- Issues each block to the core with a one-cycle init (first block) or next (later blocks) pulse, then waits for the core's digest_valid.
- Presents the final digest on a valid/ready output port.
- Sits between the host/bus interface and the core, and is the only master of the core's init, next and block inputs.

## Interface

Parameters:
- CNT_W, 61, width of the message byte counter. The length field is {byte_cnt,3'b000} zero-extended to 64 bits; the counter wraps modulo 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- s_data  in  32  message word; byte 0 is s_data[31:24].
- s_valid  in  1  s_data valid.
- s_ready  out  1  word accepted when s_valid&&s_ready.
- s_last  in  1  marks the final word of the message.
- s_bytes  in  2  valid bytes in the final word: 1..3, or 0 meaning 4. Ignored unless s_last.
- core_init  out  1  one-cycle pulse that starts the first block.
- core_next  out  1  one-cycle pulse that starts each later block.
- core_block  out  512  block to the core; word 0 is [511:480].
- core_ready  in  1  core idle.
- core_digest  in  256  core digest.
- core_digest_valid  in  1  core finished the current block.
- m_digest  out  256  final digest, H0 in [255:224].
- m_valid  out  1  m_digest valid.
- m_ready  in  1  consumer accepts the digest.
- busy  out  1  high from the first accepted word until the digest handshake completes.

## Operation

- States: FILL, START, WAIT, EXTRA, OUT.
- Internal registers:
  - buf: 16×32 block buffer.
  - w_idx: 0..15, next buffer word to write.
  - byte_cnt: message bytes accepted so far.
  - first: high until the first block is issued.
  - last_blk: the buffered block is the final block.
  - need_extra: a length-only block must follow the current one.
  - mark_extra: the 0x80 marker goes in word 0 of the extra block.
- FILL: s_ready=1. Each accepted word is written to buf[w_idx], w_idx increments, and byte_cnt increases by 4, or by s_bytes on a last word (0 counts as 4).
  - Non-last word at w_idx=15: go to START with last_blk=0.
- Last word accepted at index k with byte count b, all updates in the same cycle:
  - b=1..3: bytes b..3 of word k are replaced by 0x80 followed by zeros, e.g. b=3 gives {d[31:8],8'h80}.
  - b=0 and k<15: word k is written unmasked and word k+1 is written as 32'h80000000.
  - The length fits when (b≠0 && k≤13) or (b=0 && k≤12). In that case word 14 = len[63:32], word 15 = len[31:0], where len is computed from the updated byte count, and last_blk=1.
  - Otherwise last_blk=0 and need_extra=1, with mark_extra=(b==0 && k==15).
  - Then go to START.
- START: wait for core_ready=1, then pulse core_init if first, else core_next, for exactly one cycle. Clear first and go to WAIT.
- WAIT: hold core_block stable. On core_digest_valid=1, sampled from the cycle after the pulse onward:
  - last_blk=1: capture core_digest into m_digest and go to OUT.
  - need_extra=1: go to EXTRA.
  - Otherwise go to FILL.
  - On every exit from WAIT, clear buf to zero and reset w_idx to 0.
- EXTRA (one cycle): write word 0 = 32'h80000000 if mark_extra, and words 14/15 = len. Set last_blk=1, clear need_extra, go to START.
- OUT: m_valid=1 and m_digest held stable until m_ready. On handshake: m_valid=0, byte_cnt=0, first=1, busy=0, go to FILL.
- core_block always equals buf. Unwritten words read zero because buf is cleared per block.
- Minimum message length is 1 byte; zero-length messages are not supported.

## Timing

- Reset values:
  - State FILL, so s_ready=1 after reset.
  - core_init=0, core_next=0, core_block=0.
  - m_valid=0, m_digest=0, busy=0, byte_cnt=0, first=1.
- The pulse in START fires in the first cycle with core_ready=1. core_init and core_next are never high together and never high outside START.
- A block needs 16 accept cycles in FILL, plus 1 START cycle, plus the core latency (66 cycles from pulse to digest_valid), plus 1.
- The padded final block is issued in the cycle after the last word. An extra block adds 1 EXTRA cycle plus one full core pass.
- s_ready=0 in START, WAIT, EXTRA and OUT; the input is back-pressured during core operation.
- m_valid stays high with m_digest constant for any number of m_ready=0 cycles.
- A reset assertion in any state returns all outputs to their reset values immediately. A partially received message is discarded; the next first block uses core_init.

## Test plan

- "abc": one word 0x61626300, s_last=1, s_bytes=3 -> one core_init, block word 0=0x61626380, word 15=0x18 -> m_digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- 56-byte "abcdbcdecdefdefg…nopq", 14 words, last s_bytes=0 -> init, then next. Block 1 has word 14=0x80000000. Extra block: word 15=0x1c0 with no marker -> digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- 64-byte message (k=15, b=0) -> second block word 0=0x80000000, word 15=0x200, word 1..14=0.
- 55-byte message (k=13, b=3) -> single block, word 13 byte 3=0x80, word 15=0x1b8, no extra block.
- m_ready held 0 for 20 cycles after m_valid -> m_digest stable and s_ready=0 throughout; a handshake then gives s_ready=1 on the next cycle.
- reset_n asserted during WAIT -> outputs at reset values. A following "abc" message gives core_init and the correct digest.
